alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (3-bit op, two 32-bit operands, 32-bit result, zero and sign flags) between two requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates, drives the ALU for one cycle, registers result and flags, and returns them to the winning requester.
- Sits between the multicycle controller/datapath and the shared ALU instance.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 3, ALU operation code width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 request present.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_op  in  OPW  requester 0 ALU operation.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- rsp0_valid  out  1  requester 0 result available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp0_w  out  WIDTH  result.
- rsp0_zero  out  1  result zero flag.
- rsp0_sign  out  1  result sign flag.
- rsp0_err  out  1  illegal operation code.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_w, rsp1_zero, rsp1_sign, rsp1_err: same as requester 0, for requester 1.
- alu_op  out  OPW  to ALU.
- alu_a  out  WIDTH  to ALU.
- alu_b  out  WIDTH  to ALU.
- alu_w  in  WIDTH  from ALU.
- alu_zero  in  1  from ALU.
- alu_sign  in  1  from ALU.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1, all valids/readys 0.
  - Result, flag and err registers 0; alu_op/alu_a/alu_b 0.
- FSM:
  - IDLE: req*_ready is asserted combinationally only in IDLE, for the granted requester only.
  - On handshake, latch op/a/b and grant id; go to EXEC.
  - EXEC: alu_op/a/b driven from the latch; alu_w/zero/sign captured at the clock edge ending EXEC; go to RESP.
  - RESP: rspN_valid=1 for the granted id only; the other rsp valid stays 0. On rspN_ready=1, return to IDLE.
- Latency: handshake in cycle N, EXEC in N+1, rsp valid from N+2. Minimum 3 cycles per transaction; one transaction in flight at a time.
- Outside EXEC, alu_* outputs hold the last latched values; the ALU is idle-safe.
- Illegal op:
  - op=7 is still issued, but the captured result is forced to 0.
  - zero=1, sign=0, err=1.
  - The ALU output for op 7 is never trusted.
- Response data and flags stay stable while rsp valid is high and ready is low.
- Request inputs are ignored outside IDLE; a requester holds valid until ready.
- Simultaneous requests: arbitration per the Optional Feature. A single requester is always granted.
- Reset mid-transaction aborts it: no response is delivered and the latched request is lost.
- Flags: zero = (result == 0); sign = result[WIDTH-1]. Both are taken from the ALU unless the op is illegal.

Optional Feature:
- Macro ALU_ARB_RR_EN.
- Defined: round-robin. On a tie, grant the requester not equal to last_grant. last_grant updates on every accepted request.
- Undefined: fixed priority, requester 0 always wins a tie. last_grant is still maintained but unused.

Decomposition:
- Shared package alu_pkg:
  - Op codes ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLTU=5, XOR=6, ILLEGAL=7.
  - State enum IDLE/EXEC/RESP.
  - WIDTH/OPW defaults.
- Sub-module alu_grant2: combinational 2-way grant. Inputs: two valids, last_grant, rr-enable. Output: grant id plus any-grant.
- FSM and datapath latches stay in the top.

Test Plan:
- Single op, SUB: req0 op=1, a=5, b=7, rsp0_ready=1 -> rsp0_valid at N+2, w=0xFFFFFFFE, sign=1, zero=0, err=0. rsp1_valid stays 0.
- Zero flag, XOR: req1 op=6, a=b=0xA5A5A5A5 -> rsp1 w=0, zero=1, sign=0.
- Tie arbitration: both valid from reset, each op=0 (ADD 1+2 and 3+4).
  - With ALU_ARB_RR_EN: req0 served first (last_grant=1 at reset), then req1 (w=3, then w=7).
  - Without the macro: req0 first; if req0 re-requests at once it wins again.
- Backpressure: rsp0_ready=0 for 5 cycles -> rsp0_valid and w stable. req1_ready=0 throughout. req1 is accepted the cycle after rsp0 handshake plus the IDLE cycle.
- Illegal op: op=7, a=1, b=1 -> w=0, zero=1, sign=0, err=1.
- Reset mid-EXEC: drop rst_n during EXEC -> all outputs 0 immediately. After release, no stale response; a new request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing arbiter:
//   - default operand/result width and op-code width
//   - ALU op-code encoding (ADD..XOR, op 7 is illegal)
//   - arbiter FSM state encoding
//   - helper to classify an op code as illegal
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_OPW   = 3;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_AND     = 3'd2,
    OP_OR      = 3'd3,
    OP_SLT     = 3'd4,
    OP_SLTU    = 3'd5,
    OP_XOR     = 3'd6,
    OP_ILLEGAL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // The ALU output for the illegal code is never trusted; callers use this
  // to substitute a fixed result.
  function automatic logic op_is_illegal(input logic [ALU_OPW-1:0] op);
    logic illegal;
    if (op == OP_ILLEGAL) begin
      illegal = 1'b1;
    end else begin
      illegal = 1'b0;
    end
    return illegal;
  endfunction

endpackage : alu_pkg

// File: rtl/alu_grant2.sv
// -----------------------------------------------------------------------------
// alu_grant2
// Combinational two-way grant for the shared ALU.
//   valid0_i      requester 0 has a request pending
//   valid1_i      requester 1 has a request pending
//   last_grant_i  id of the requester granted most recently
//   rr_en_i       1: round-robin on a tie, 0: requester 0 wins a tie
//   grant_id_o    id of the granted requester (meaningful when any_grant_o)
//   any_grant_o   at least one requester is pending
// -----------------------------------------------------------------------------
module alu_grant2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  input  logic rr_en_i,
  output logic grant_id_o,
  output logic any_grant_o
);

  // Select the winner; a lone requester always wins, ties use the policy.
  always_comb begin
    grant_id_o  = 1'b0;
    any_grant_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      if (rr_en_i) begin
        // Round-robin: hand the ALU to whoever did not have it last.
        grant_id_o = ~last_grant_i;
      end else begin
        grant_id_o = 1'b0;
      end
    end else if (valid1_i) begin
      grant_id_o = 1'b1;
    end else begin
      grant_id_o = 1'b0;
    end
  end

endmodule : alu_grant2

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one external combinational ALU between two requesters. A request is
// accepted in IDLE, the ALU is driven from latched operands for one EXEC
// cycle, the result/flags are registered at the end of EXEC, and RESP holds
// them for the granted requester until it consumes them.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   -> round-robin on simultaneous requests
//   undefined -> fixed priority, requester 0 wins a tie
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   reqN_valid/ready                request handshake for requester N
//   reqN_op/a/b                     requested op code and operands
//   rspN_valid/ready                response handshake for requester N
//   rspN_w/zero/sign/err            result, zero flag, sign flag, illegal op
//   alu_op/a/b                      drive to the shared ALU (latched values)
//   alu_w/zero/sign                 result and flags from the shared ALU
// -----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_w,
  output logic             rsp0_zero,
  output logic             rsp0_sign,
  output logic             rsp0_err,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_w,
  output logic             rsp1_zero,
  output logic             rsp1_sign,
  output logic             rsp1_err,
  // shared ALU
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_zero,
  input  logic             alu_sign
);

`ifdef ALU_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_e       state_q, state_d;

  // Latched request (also drives the ALU, so it doubles as the idle value).
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             gid_q, gid_d;
  logic             last_grant_q, last_grant_d;

  // Captured result and flags, shared by both response channels.
  logic [WIDTH-1:0] w_q, w_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             err_q, err_d;

  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;

  logic             grant_id_s;
  logic             any_grant_s;
  logic             handshake_s;
  logic             rsp_fire_s;

  alu_grant2 u_grant (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .rr_en_i      (RR_EN),
    .grant_id_o   (grant_id_s),
    .any_grant_o  (any_grant_s)
  );

  // Request acceptance: only in IDLE and only towards the granted requester.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    handshake_s = 1'b0;
    if ((state_q == ST_IDLE) && any_grant_s) begin
      handshake_s = 1'b1;
      req0_ready  = ~grant_id_s;
      req1_ready  = grant_id_s;
    end else begin
      handshake_s = 1'b0;
    end
  end

  // Response consumption by the owner of the pending result.
  always_comb begin
    rsp_fire_s = 1'b0;
    if (state_q == ST_RESP) begin
      if (gid_q) begin
        rsp_fire_s = rsp1_ready;
      end else begin
        rsp_fire_s = rsp0_ready;
      end
    end else begin
      rsp_fire_s = 1'b0;
    end
  end

  // FSM next state and response-valid next values.
  always_comb begin
    state_d      = state_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Result becomes visible to the granted requester only.
        state_d      = ST_RESP;
        rsp0_valid_d = ~gid_q;
        rsp1_valid_d = gid_q;
      end
      ST_RESP: begin
        if (rsp_fire_s) begin
          state_d      = ST_IDLE;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
      end
    endcase
  end

  // Request latch: captured on the accepting handshake, held otherwise.
  always_comb begin
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    gid_d        = gid_q;
    last_grant_d = last_grant_q;
    if (handshake_s) begin
      gid_d        = grant_id_s;
      last_grant_d = grant_id_s;
      if (grant_id_s) begin
        op_d = req1_op;
        a_d  = req1_a;
        b_d  = req1_b;
      end else begin
        op_d = req0_op;
        a_d  = req0_a;
        b_d  = req0_b;
      end
    end else begin
      gid_d = gid_q;
    end
  end

  // Result capture at the end of EXEC; held stable through RESP.
  always_comb begin
    w_d    = w_q;
    zero_d = zero_q;
    sign_d = sign_q;
    err_d  = err_q;
    if (state_q == ST_EXEC) begin
      if (op_is_illegal(op_q)) begin
        // Whatever the ALU produced for op 7 is discarded.
        w_d    = {WIDTH{1'b0}};
        zero_d = 1'b1;
        sign_d = 1'b0;
        err_d  = 1'b1;
      end else begin
        w_d    = alu_w;
        zero_d = alu_zero;
        sign_d = alu_sign;
        err_d  = 1'b0;
      end
    end else begin
      err_d = err_q;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= {OPW{1'b0}};
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      gid_q        <= 1'b0;
      last_grant_q <= 1'b1;
      w_q          <= {WIDTH{1'b0}};
      zero_q       <= 1'b0;
      sign_q       <= 1'b0;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      gid_q        <= gid_d;
      last_grant_q <= last_grant_d;
      w_q          <= w_d;
      zero_q       <= zero_d;
      sign_q       <= sign_d;
      err_q        <= err_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_w     = w_q;
  assign rsp0_zero  = zero_q;
  assign rsp0_sign  = sign_q;
  assign rsp0_err   = err_q;

  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_w     = w_q;
  assign rsp1_zero  = zero_q;
  assign rsp1_sign  = sign_q;
  assign rsp1_err   = err_q;

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Scoreboard bench: each accepted request pushes its expected response into a
// per-requester queue; a monitor compares every presented response with the
// queue head and pops on the response handshake. The shared ALU is modelled
// here and returns garbage for op 7 so result forcing is observable.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  typedef struct packed {
    logic        err;
    logic        sign;
    logic        zero;
    logic [31:0] w;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_w, rsp1_w;
  logic        rsp0_zero, rsp0_sign, rsp0_err, rsp1_zero, rsp1_sign, rsp1_err;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_w, alu_t;
  logic        alu_zero, alu_sign;

  int   n_cmp = 0;
  int   n_bad = 0;
  rsp_t exp0[$];
  rsp_t exp1[$];
  int   grant_log[$];
  bit   rnd_on;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_w(rsp0_w),
    .rsp0_zero(rsp0_zero), .rsp0_sign(rsp0_sign), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_w(rsp1_w),
    .rsp1_zero(rsp1_zero), .rsp1_sign(rsp1_sign), .rsp1_err(rsp1_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_w(alu_w), .alu_zero(alu_zero), .alu_sign(alu_sign)
  );

  // Reference behaviour of one transaction, straight from the op definitions.
  function automatic rsp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    logic [31:0] w;
    case (op)
      3'd0: w = a + b;
      3'd1: w = a - b;
      3'd2: w = a & b;
      3'd3: w = a | b;
      3'd4: w = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: w = (a < b) ? 32'd1 : 32'd0;
      3'd6: w = a ^ b;
      default: w = 32'd0;
    endcase
    r.w    = w;
    r.zero = (w == 32'd0);
    r.sign = w[31];
    r.err  = (op == 3'd7);
    return r;
  endfunction

  // Shared ALU model; op 7 yields deliberately wrong data and flags.
  always_comb begin
    alu_t = ref_model(alu_op, alu_a, alu_b).w;
    if (alu_op == 3'd7) begin
      alu_w    = 32'hDEAD_BEEF;
      alu_zero = 1'b0;
      alu_sign = 1'b1;
    end else begin
      alu_w    = alu_t;
      alu_zero = (alu_t == 32'd0);
      alu_sign = alu_t[31];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Scoreboard side: compare whatever is presented, pop on handshake.
  task automatic mon(input int id);
    rsp_t act;
    rsp_t e;
    bit   rdy;
    if (id == 0) begin
      act = {rsp0_err, rsp0_sign, rsp0_zero, rsp0_w};
      rdy = rsp0_ready;
    end else begin
      act = {rsp1_err, rsp1_sign, rsp1_zero, rsp1_w};
      rdy = rsp1_ready;
    end
    if ((id == 0 ? exp0.size() : exp1.size()) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_rsp%0d: got %h expected no response", id, act);
    end else begin
      e = (id == 0) ? exp0[0] : exp1[0];
      chk($sformatf("rsp%0d_data", id), {29'd0, act}, {29'd0, e});
      if (rdy) begin
        if (id == 0) void'(exp0.pop_front());
        else void'(exp1.pop_front());
      end
    end
  endtask

  // Monitor process, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid && rsp1_valid) begin
        chk("rsp_both_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd1);
      end
      if (rsp0_valid === 1'b1) mon(0);
      if (rsp1_valid === 1'b1) mon(1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise a request, hold it until accepted (bounded), push expectation.
  task automatic issue(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if ((id == 0 ? req0_ready : req1_ready) === 1'b1) begin
        done = 1'b1;
        grant_log.push_back(id);
        if (id == 0) exp0.push_back(ref_model(op, a, b));
        else exp1.push_back(ref_model(op, a, b));
      end
      @(posedge clk);
      #1;
    end
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout%0d: got no ready expected ready", id);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp0.size() + exp1.size()) != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(exp0.size() + exp1.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp0.delete();
    exp1.delete();
    grant_log.delete();
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    chk("rst_result", {28'd0, rsp0_err, rsp0_sign, rsp0_zero, rsp0_w}, 64'd0);
    chk("rst_alu", {29'd0, alu_op, alu_a}, 64'd0);
    chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
    cyc(1);

    // SUB 5-7 with latency check: handshake N, EXEC N+1, valid at N+2.
    issue(0, 3'd1, 32'd5, 32'd7);
    @(negedge clk);
    chk("exec_rsp_valid", {63'd0, rsp0_valid}, 64'd0);
    chk("exec_alu_drive", {29'd0, alu_op, alu_a}, {29'd0, 3'd1, 32'd5});
    chk("exec_alu_b", {32'd0, alu_b}, 64'd7);
    cyc(1);
    @(negedge clk);
    chk("resp_valid_n2", {62'd0, rsp1_valid, rsp0_valid}, 64'd1);
    chk("sub_w", {32'd0, rsp0_w}, 64'hFFFF_FFFE);
    drain();

    // XOR to zero on requester 1.
    issue(1, 3'd6, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    drain();

    // Illegal op.
    issue(0, 3'd7, 32'd1, 32'd1);
    drain();

    // Tie from reset: both policies serve req0 then req1.
    do_reset();
    fork
      issue(0, 3'd0, 32'd1, 32'd2);
      issue(1, 3'd0, 32'd3, 32'd4);
    join
    drain();
    chk("tie_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("tie_order", {grant_log[0][31:0], grant_log[1][31:0]}, {32'd0, 32'd1});
    end

    // Tie with req0 re-requesting immediately.
    do_reset();
    fork
      begin
        issue(0, 3'd0, 32'd10, 32'd1);
        issue(0, 3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      end
      issue(1, 3'd4, 32'hFFFF_FFFF, 32'd1);
    join
    drain();
    chk("rereq_count", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() == 3) begin
`ifdef ALU_ARB_RR_EN
      chk("rereq_order", {16'd0, grant_log[0][15:0], grant_log[1][15:0], grant_log[2][15:0]}, {16'd0, 16'd0, 16'd1, 16'd0});
`else
      chk("rereq_order", {16'd0, grant_log[0][15:0], grant_log[1][15:0], grant_log[2][15:0]}, {16'd0, 16'd0, 16'd0, 16'd1});
`endif
    end

    // Backpressure on rsp0 while req1 waits.
    rsp0_ready = 1'b0;
    issue(0, 3'd3, 32'h1234_0000, 32'h0000_5678);
    cyc(1);
    fork
      issue(1, 3'd5, 32'd3, 32'd9);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
      chk("bp_req1_ready", {63'd0, req1_ready}, 64'd0);
      cyc(1);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {63'd0, req1_ready}, 64'd0);
    cyc(1);
    @(negedge clk);
    chk("bp_idle_ready", {63'd0, req1_ready}, 64'd1);
    wait fork;
    drain();

    // Reset during EXEC aborts the transaction.
    issue(0, 3'd0, 32'd10, 32'd20);
    #2;
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    #1;
    chk("abort_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    chk("abort_result", {28'd0, rsp0_err, rsp0_sign, rsp0_zero, rsp0_w}, 64'd0);
    chk("abort_alu", {29'd0, alu_op, alu_a}, 64'd0);
    chk("abort_alu_b", {32'd0, alu_b}, 64'd0);
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_stale", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    end
    cyc(1);
    issue(0, 3'd1, 32'd100, 32'd1);
    drain();

    // Randomised traffic with random response backpressure.
    rnd_on = 1'b1;
    fork
      begin
        fork
          for (int i = 0; i < 40; i++) begin
            logic [31:0] a0;
            a0 = $urandom;
            cyc($urandom_range(0, 2));
            issue(0, 3'($urandom_range(0, 7)), a0, ($urandom_range(0, 3) == 0) ? a0 : $urandom);
          end
          for (int j = 0; j < 40; j++) begin
            logic [31:0] a1;
            a1 = $urandom;
            cyc($urandom_range(0, 2));
            issue(1, 3'($urandom_range(0, 7)), a1, ($urandom_range(0, 3) == 0) ? a1 : $urandom);
          end
        join
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        rsp0_ready = ($urandom_range(0, 3) != 0);
        rsp1_ready = ($urandom_range(0, 3) != 0);
        cyc(1);
      end
    join
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu_share_arbiter
